// File: rtl/display_pkg.sv
// Shared constants and types for the 3-digit display back end.
// Segment patterns here are active-high, bit order gfedcba.
package display_pkg;

    localparam logic [1:0] DIG_SIGN = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_ONES = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;

endpackage

// File: rtl/seg7_encoder.sv
// BCD digit to active-high gfedcba segment pattern.
// Non-decimal codes 10..15 render blank.
module seg7_encoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (bcd)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digit_driver.sv
// Multiplexed 3-digit display driver: double-dabble conversion into a
// pending buffer, wrap-aligned commit, and anode blanking on digit change.
module digit_driver
    import display_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES   = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] digit,
    input  logic [5:0] display_value,
    input  logic       is_negative,
    input  logic       is_dec,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] an,
    output logic       busy
);

    localparam logic        POL      = SEG_ACTIVE_LOW;
    localparam logic [15:0] BLANK_LD = 16'(BLANK_CYCLES);

    conv_state_t state_q, state_d;
    logic [7:0]  snap_q, snap_d;
    logic [5:0]  bin_q, bin_d;
    logic [7:0]  bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic [3:0]  pend_tens_q, pend_tens_d;
    logic [3:0]  pend_ones_q, pend_ones_d;
    logic        pend_neg_q, pend_neg_d;
    logic        pend_dp_q, pend_dp_d;
    logic        pend_valid_q, pend_valid_d;

    logic [3:0]  com_tens_q, com_tens_d;
    logic [3:0]  com_ones_q, com_ones_d;
    logic        com_neg_q, com_neg_d;
    logic        com_dp_q, com_dp_d;

    logic [1:0]  prev_digit_q;
    logic [15:0] blank_q, blank_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [2:0]  an_q, an_d;

    logic [7:0]  snap_in;
    logic [7:0]  adj;
    logic [13:0] sh;
    logic        wrap;
    logic [3:0]  enc_in;
    logic [6:0]  enc_seg;
    logic [6:0]  seg_on;
    logic        dp_on;
    logic [2:0]  an_on;

    assign snap_in = {display_value, is_negative, is_dec};
    assign wrap    = (prev_digit_q == DIG_ONES) && (digit == DIG_SIGN);

    // Double-dabble step: correct each nibble, then shift bcd:bin left.
    always_comb begin
        adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        sh       = {adj, bin_q} << 1;
    end

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        pend_tens_d  = pend_tens_q;
        pend_ones_d  = pend_ones_q;
        pend_neg_d   = pend_neg_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        com_tens_d   = com_tens_q;
        com_ones_d   = com_ones_q;
        com_neg_d    = com_neg_q;
        com_dp_d     = com_dp_q;

        if (wrap && pend_valid_q) begin
            com_tens_d   = pend_tens_q;
            com_ones_d   = pend_ones_q;
            com_neg_d    = pend_neg_q;
            com_dp_d     = pend_dp_q;
            pend_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (snap_in != snap_q) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                snap_d  = snap_in;
                bin_d   = display_value;
                bcd_d   = 8'd0;
                cnt_d   = 3'd6;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = sh[13:6];
                bin_d = sh[5:0];
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                pend_tens_d  = bcd_q[7:4];
                pend_ones_d  = bcd_q[3:0];
                pend_neg_d   = snap_q[1];
                pend_dp_d    = snap_q[0];
                pend_valid_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_comb begin
        if (digit != prev_digit_q) begin
            blank_d = BLANK_LD;
        end else if (blank_q != 16'd0) begin
            blank_d = blank_q - 16'd1;
        end else begin
            blank_d = blank_q;
        end
    end

    assign enc_in = (digit == DIG_TENS) ? com_tens_q : com_ones_q;

    seg7_encoder u_enc (
        .bcd (enc_in),
        .seg (enc_seg)
    );

    always_comb begin
        seg_on = SEG_BLANK;
        dp_on  = 1'b0;
        an_on  = 3'b000;
        unique case (digit)
            DIG_SIGN: begin
                an_on = 3'b100;
                if (com_neg_q) seg_on = SEG_MINUS;
            end
            DIG_TENS: begin
                an_on = 3'b010;
                dp_on = com_dp_q;
                // Leading zero suppressed unless it sits before the point.
                if (com_dp_q || (com_tens_q != 4'd0)) seg_on = enc_seg;
            end
            DIG_ONES: begin
                an_on  = 3'b001;
                seg_on = enc_seg;
            end
            default: begin
                an_on = 3'b000;
            end
        endcase
        if (blank_d != 16'd0) an_on = 3'b000;
        seg_d = seg_on ^ {7{POL}};
        dp_d  = dp_on ^ POL;
        an_d  = an_on ^ {3{POL}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            snap_q       <= 8'd0;
            bin_q        <= 6'd0;
            bcd_q        <= 8'd0;
            cnt_q        <= 3'd0;
            busy_q       <= 1'b0;
            pend_tens_q  <= 4'd0;
            pend_ones_q  <= 4'd0;
            pend_neg_q   <= 1'b0;
            pend_dp_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            com_tens_q   <= 4'd0;
            com_ones_q   <= 4'd0;
            com_neg_q    <= 1'b0;
            com_dp_q     <= 1'b0;
            prev_digit_q <= DIG_SIGN;
            blank_q      <= BLANK_LD;
            seg_q        <= {7{POL}};
            dp_q         <= POL;
            an_q         <= {3{POL}};
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            pend_tens_q  <= pend_tens_d;
            pend_ones_q  <= pend_ones_d;
            pend_neg_q   <= pend_neg_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            com_tens_q   <= com_tens_d;
            com_ones_q   <= com_ones_d;
            com_neg_q    <= com_neg_d;
            com_dp_q     <= com_dp_d;
            prev_digit_q <= digit;
            blank_q      <= blank_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule
